sdf_bf_stage8: RTL and testbench
================================

# sdf_bf_stage8

Radix-2 single-path delay-feedback (SDF) decimation-in-frequency butterfly stage with an 8-entry complex delay line. It consumes the `state`, `w_r` and `w_i` outputs of the depth-8 twiddle ROM, which is clocked from the same `in_valid`. It is the last radix-2 stage of the 512-point FFT pipeline. It turns each 16-sample group into 8 butterfly sums followed by 8 twiddled differences.

## Interface
- `WIDTH`, default 24: signed sample and twiddle width.
- `FRAC`, default 8: twiddle fraction bits (256 = 1.0).
- `DEPTH`, default 8: delay-line length. Must equal the ROM half-group length.
- `clk`, in, 1: single clock, rising edge.
- `rst`, in, 1: asynchronous, active-high reset.
- `in_valid`, in, 1: sample present on `din_r`/`din_i` this cycle.
- `din_r`, `din_i`, in, WIDTH each: signed input sample.
- `state`, in, 2: 0 = FILL, 1 = BF, 2 = TW, 3 = illegal. Cycle-aligned with `in_valid`.
- `w_r`, `w_i`, in, WIDTH each: signed twiddle, Q(WIDTH-FRAC).FRAC. Only used in TW.
- `out_valid`, out, 1: `dout_*` holds a result.
- `dout_r`, `dout_i`, out, WIDTH each: signed output sample.

## Operation
- The stage advances only on cycles with `in_valid`=1. With `in_valid`=0:
  - the delay line holds;
  - `out_valid` goes 0 next cycle;
  - `dout_*` hold their last value.
- The delay head is the oldest entry, h. Each advancing cycle pushes one entry at the tail and pops the head.
- FILL (state 0, or illegal state 3):
  - push din;
  - no output.
- BF (state 1):
  - output h + din;
  - push h − din.
- TW (state 2):
  - push din;
  - output h × w.
- Add and subtract are WIDTH-bit two's complement with wrap, no saturation. Upstream scaling guarantees headroom.
- Complex multiply uses full-precision 2·WIDTH-bit products:
  - re = hr·wr − hi·wi
  - im = hr·wi + hi·wr
  - Each result is then rounded: add 2^(FRAC−1), arithmetic shift right by FRAC, truncate to WIDTH.
- Steady state is 8 cycles BF, then 8 cycles TW, repeating. The stage never inspects the twiddle index. It trusts `state` and `w_*`.

## Timing
- Latency is 1 cycle. Results computed in advancing cycle N appear on registered `dout_*` with `out_valid`=1 in cycle N+1.
- `out_valid` at N+1 = `in_valid` at N AND (`state` at N ∈ {1,2}).
- On reset assertion, asynchronously and for as long as `rst`=1:
  - every delay entry = 0;
  - `dout_r` = `dout_i` = 0;
  - `out_valid` = 0.
- Reset mid-frame discards all buffered data. The first cycle after release is treated as whatever `state` shows. Restarting the group in step is the responsibility of the ROM, which resets alongside.
- `in_valid` gaps may occur at any point: inside FILL, BF or TW, or at a BF/TW boundary. Pairing between the stored h and the incoming din must be unchanged by gaps.
- The multiplier path is combinational into the output register. No internal pipelining is permitted, because that would change the 1-cycle latency.

## Structure
- Shared package `fft_pkg` holds:
  - `WIDTH` and `FRAC` constants;
  - the state encoding `ST_FILL`=0, `ST_BF`=1, `ST_TW`=2;
  - the complex sample struct (re/im, WIDTH each).
- One sub-module, `cmul_round`: a combinational complex multiply with round-half-up and FRAC shift, shared with the other SDF stages.
- The delay line is an in-module shift register of DEPTH complex entries.

## Test plan
- Reset:
  - Assert `rst` with random inputs. `dout_*`=0 and `out_valid`=0 immediately, with no clock edge needed.
  - Release `rst` with `in_valid`=0. Outputs stay 0.
- Fill then butterfly:
  - Drive x[n]=n·256 (real, imaginary 0) for n=0..7 in FILL. `out_valid` stays 0.
  - Drive n=8..15 in BF. Outputs are (2n−8)·256: 2048, 2560, …, 5632, each one cycle after its input.
  - All stored differences equal −2048.
- Twiddle:
  - In TW, w=(256,0) gives output (−2048, 0).
  - w=(0,−256) with h=(−2048,0) gives (0, 2048).
- Rounding:
  - h=(1,0) and w=(181,−181) gives (1, −1), by (181+128)>>8 and (−181+128)>>8.
  - h=(−3,0) and w=(128,0) gives (−1,0).
- Gaps:
  - Hold `in_valid`=0 for 3 cycles in mid BF. `out_valid` is 0 for exactly those 3 result slots.
  - After resuming, the output sequence equals the gap-free run.
- Mid-frame reset:
  - Pulse `rst` during TW. All outputs are 0 at once.
  - Refill with new data. Outputs carry no residue from pre-reset samples.

Source files
------------

// File: rtl/fft_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fft_pkg - shared widths, state encoding and complex type for SDF stages
// Rev 1.0
// ---------------------------------------------------------------------------
package fft_pkg;

  localparam int WIDTH = 24;
  localparam int FRAC  = 8;

  localparam logic [1:0] ST_FILL = 2'd0;
  localparam logic [1:0] ST_BF   = 2'd1;
  localparam logic [1:0] ST_TW   = 2'd2;

  typedef struct packed {
    logic signed [WIDTH-1:0] re;
    logic signed [WIDTH-1:0] im;
  } cplx_t;

endpackage
`default_nettype wire

// File: rtl/cmul_round.sv
`default_nettype none
// ---------------------------------------------------------------------------
// cmul_round - combinational complex multiply, round-half-up, FRAC shift
// Rev 1.0
// ---------------------------------------------------------------------------
module cmul_round #(
  parameter int WIDTH = fft_pkg::WIDTH,
  parameter int FRAC  = fft_pkg::FRAC
) (
  input  logic signed [WIDTH-1:0] a_re_i,
  input  logic signed [WIDTH-1:0] a_im_i,
  input  logic signed [WIDTH-1:0] b_re_i,
  input  logic signed [WIDTH-1:0] b_im_i,
  output logic signed [WIDTH-1:0] p_re_o,
  output logic signed [WIDTH-1:0] p_im_o
);

  // One guard bit above the 2*WIDTH product so the sum/difference cannot wrap.
  localparam int PW = 2*WIDTH + 1;
  localparam logic signed [PW-1:0] RND_BIAS = {{(PW-1){1'b0}}, 1'b1} << (FRAC-1);

  logic signed [PW-1:0] a_re_x, a_im_x, b_re_x, b_im_x;
  logic signed [PW-1:0] prod_rr, prod_ii, prod_ri, prod_ir;
  logic signed [PW-1:0] sum_re, sum_im;
  logic                 unused_bits;

  assign a_re_x = PW'(a_re_i);
  assign a_im_x = PW'(a_im_i);
  assign b_re_x = PW'(b_re_i);
  assign b_im_x = PW'(b_im_i);

  assign prod_rr = a_re_x * b_re_x;
  assign prod_ii = a_im_x * b_im_x;
  assign prod_ri = a_re_x * b_im_x;
  assign prod_ir = a_im_x * b_re_x;

  assign sum_re = prod_rr - prod_ii + RND_BIAS;
  assign sum_im = prod_ri + prod_ir + RND_BIAS;

  // Slicing above FRAC is the arithmetic shift followed by truncation.
  assign p_re_o = sum_re[FRAC +: WIDTH];
  assign p_im_o = sum_im[FRAC +: WIDTH];

  assign unused_bits = ^{sum_re[FRAC-1:0], sum_re[PW-1:FRAC+WIDTH],
                         sum_im[FRAC-1:0], sum_im[PW-1:FRAC+WIDTH]};

endmodule
`default_nettype wire

// File: rtl/sdf_bf_stage8.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sdf_bf_stage8 - radix-2 DIF SDF butterfly stage with DEPTH-entry feedback
// Rev 1.0
// ---------------------------------------------------------------------------
module sdf_bf_stage8 #(
  parameter int WIDTH = fft_pkg::WIDTH,
  parameter int FRAC  = fft_pkg::FRAC,
  parameter int DEPTH = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  input  logic signed [WIDTH-1:0] din_r,
  input  logic signed [WIDTH-1:0] din_i,
  input  logic [1:0]              state,
  input  logic signed [WIDTH-1:0] w_r,
  input  logic signed [WIDTH-1:0] w_i,
  output logic                    out_valid,
  output logic signed [WIDTH-1:0] dout_r,
  output logic signed [WIDTH-1:0] dout_i
);

  import fft_pkg::*;

  // Index 0 is the head (oldest entry); pushes enter at DEPTH-1.
  logic signed [WIDTH-1:0] dl_re_q [DEPTH];
  logic signed [WIDTH-1:0] dl_im_q [DEPTH];

  logic signed [WIDTH-1:0] dout_r_q, dout_i_q, dout_r_d, dout_i_d;
  logic                    out_valid_q, out_valid_d;
  logic signed [WIDTH-1:0] push_re_d, push_im_d;
  logic signed [WIDTH-1:0] sum_re, sum_im, dif_re, dif_im;
  logic signed [WIDTH-1:0] prod_re, prod_im;

  assign sum_re = dl_re_q[0] + din_r;
  assign sum_im = dl_im_q[0] + din_i;
  assign dif_re = dl_re_q[0] - din_r;
  assign dif_im = dl_im_q[0] - din_i;

  cmul_round #(
    .WIDTH (WIDTH),
    .FRAC  (FRAC)
  ) u_cmul (
    .a_re_i (dl_re_q[0]),
    .a_im_i (dl_im_q[0]),
    .b_re_i (w_r),
    .b_im_i (w_i),
    .p_re_o (prod_re),
    .p_im_o (prod_im)
  );

  always_comb begin
    push_re_d   = din_r;
    push_im_d   = din_i;
    dout_r_d    = dout_r_q;
    dout_i_d    = dout_i_q;
    out_valid_d = 1'b0;
    if (in_valid) begin
      if (state == ST_BF) begin
        push_re_d   = dif_re;
        push_im_d   = dif_im;
        dout_r_d    = sum_re;
        dout_i_d    = sum_im;
        out_valid_d = 1'b1;
      end else if (state == ST_TW) begin
        dout_r_d    = prod_re;
        dout_i_d    = prod_im;
        out_valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        dl_re_q[i] <= '0;
        dl_im_q[i] <= '0;
      end
      dout_r_q    <= '0;
      dout_i_q    <= '0;
      out_valid_q <= 1'b0;
    end else begin
      dout_r_q    <= dout_r_d;
      dout_i_q    <= dout_i_d;
      out_valid_q <= out_valid_d;
      if (in_valid) begin
        for (int i = 0; i < DEPTH-1; i++) begin
          dl_re_q[i] <= dl_re_q[i+1];
          dl_im_q[i] <= dl_im_q[i+1];
        end
        dl_re_q[DEPTH-1] <= push_re_d;
        dl_im_q[DEPTH-1] <= push_im_d;
      end
    end
  end

  assign dout_r    = dout_r_q;
  assign dout_i    = dout_i_q;
  assign out_valid = out_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_sdf_bf_stage8.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_sdf_bf_stage8 - directed vector bench for the SDF butterfly stage
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_sdf_bf_stage8;

  localparam int W = 24;

  typedef struct {
    bit         iv;
    logic [1:0] st;
    int         dr, di, wr, wi;
    bit         eov;
    int         er, ei;
  } vec_t;

  logic                clk = 1'b0;
  logic                rst = 1'b0;
  logic                in_valid;
  logic signed [W-1:0] din_r, din_i, w_r, w_i;
  logic [1:0]          state;
  logic                out_valid;
  logic signed [W-1:0] dout_r, dout_i;

  int n_total = 0;
  int n_pass  = 0;
  vec_t tbl[$];

  sdf_bf_stage8 #(.WIDTH(24), .FRAC(8), .DEPTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .din_r     (din_r),
    .din_i     (din_i),
    .state     (state),
    .w_r       (w_r),
    .w_i       (w_i),
    .out_valid (out_valid),
    .dout_r    (dout_r),
    .dout_i    (dout_i)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(bit iv, logic [1:0] st, int dr, int di, int wr, int wi,
                              bit eov, int er, int ei);
    vec_t v;
    v.iv = iv; v.st = st; v.dr = dr; v.di = di; v.wr = wr; v.wi = wi;
    v.eov = eov; v.er = er; v.ei = ei;
    return v;
  endfunction

  task automatic check(input string nm, input bit eov, input int er, input int ei);
    n_total++;
    if (out_valid === eov && dout_r === W'(er) && dout_i === W'(ei)) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got ov=%0b (%0d,%0d) expected ov=%0b (%0d,%0d)",
               nm, out_valid, dout_r, dout_i, eov, er, ei);
    end
  endtask

  task automatic cyc(input bit iv, input logic [1:0] st, input int dr, input int di,
                     input int wr, input int wi, input bit eov, input int er,
                     input int ei, input string nm);
    @(negedge clk);
    in_valid = iv;
    state    = st;
    din_r    = W'(dr);
    din_i    = W'(di);
    w_r      = W'(wr);
    w_i      = W'(wi);
    @(posedge clk);
    #1;
    check(nm, eov, er, ei);
  endtask

  // Idle cycle with scrambled inputs: nothing may move.
  task automatic idle(input int er, input int ei, input string nm);
    cyc(1'b0, 2'($urandom_range(0, 3)), int'($urandom), int'($urandom),
        int'($urandom), int'($urandom), 1'b0, er, ei, nm);
  endtask

  initial begin
    int twr_c[8] = '{256, 0, 128, 181, 256, 256, 256, 256};
    int twi_c[8] = '{0, -256, 0, -181, 0, 0, 0, 0};
    int ec_r[8]  = '{-2048, 0, -1024, -1448, -2048, -2048, -2048, -2048};
    int ec_i[8]  = '{0, 2048, 0, 1448, 0, 0, 0, 0};
    int a_r[8]   = '{1, -3, 300, 30, 40, 50, 60, 70};
    int a_i[8]   = '{0, 0, -50, 3, 4, 5, 6, 7};
    int b_r[8]   = '{0, 0, 100, 3, 4, 5, 6, 7};
    int b_i[8]   = '{0, 0, 20, -3, -4, -5, -6, -7};
    int ed_r[8]  = '{1, -3, 400, 33, 44, 55, 66, 77};
    int ed_i[8]  = '{0, 0, -30, 0, 0, 0, 0, 0};
    int te_r[8]  = '{181, 128, 256, 0, 256, 256, 256, 256};
    int te_i[8]  = '{-181, 0, 0, 256, 0, 0, 0, 0};
    int ee_r[8]  = '{1, -1, 200, -6, 36, 45, 54, 63};
    int ee_i[8]  = '{-1, 0, -70, 27, 8, 10, 12, 14};

    in_valid = 1'b1;
    state    = 2'($urandom_range(0, 3));
    din_r    = W'($urandom);
    din_i    = W'($urandom);
    w_r      = W'($urandom);
    w_i      = W'($urandom);

    // Asynchronous reset before any clock edge
    #2 rst = 1'b1;
    #1 check("rst_async", 1'b0, 0, 0);
    repeat (2) @(posedge clk);
    #1 check("rst_hold", 1'b0, 0, 0);
    @(negedge clk);
    in_valid = 1'b0;
    rst      = 1'b0;
    idle(0, 0, "post_rst0");
    idle(0, 0, "post_rst1");

    // Group 1: ramp fill (first two in illegal state), butterflies, twiddles
    for (int n = 0; n < 8; n++)
      tbl.push_back(mk(1'b1, (n < 2) ? 2'd3 : 2'd0, n*256, 0, 0, 0, 1'b0, 0, 0));
    for (int n = 8; n < 16; n++)
      tbl.push_back(mk(1'b1, 2'd1, n*256, 0, 0, 0, 1'b1, (2*n-8)*256, 0));
    for (int k = 0; k < 8; k++)
      tbl.push_back(mk(1'b1, 2'd2, a_r[k], a_i[k], twr_c[k], twi_c[k], 1'b1, ec_r[k], ec_i[k]));
    // Group 2: complex data, rounding cases in the twiddle half
    for (int k = 0; k < 8; k++)
      tbl.push_back(mk(1'b1, 2'd1, b_r[k], b_i[k], 0, 0, 1'b1, ed_r[k], ed_i[k]));
    for (int k = 0; k < 8; k++)
      tbl.push_back(mk(1'b1, 2'd2, 0, 0, te_r[k], te_i[k], 1'b1, ee_r[k], ee_i[k]));

    foreach (tbl[k])
      cyc(tbl[k].iv, tbl[k].st, tbl[k].dr, tbl[k].di, tbl[k].wr, tbl[k].wi,
          tbl[k].eov, tbl[k].er, tbl[k].ei, $sformatf("vec%0d", k));

    // Gaps in FILL, mid BF, at the BF/TW boundary and inside TW
    for (int n = 0; n < 8; n++) begin
      cyc(1'b1, 2'd0, n*256, 0, 0, 0, 1'b0, 63, 14, $sformatf("gfill%0d", n));
      if (n == 2) idle(63, 14, "gfill_idle");
    end
    for (int n = 8; n < 12; n++)
      cyc(1'b1, 2'd1, n*256, 0, 0, 0, 1'b1, (2*n-8)*256, 0, $sformatf("gbf%0d", n));
    for (int g = 0; g < 3; g++)
      idle(3584, 0, $sformatf("gbf_idle%0d", g));
    for (int n = 12; n < 16; n++)
      cyc(1'b1, 2'd1, n*256, 0, 0, 0, 1'b1, (2*n-8)*256, 0, $sformatf("gbf%0d", n));
    idle(5632, 0, "gbound_idle");
    for (int k = 0; k < 4; k++) begin
      cyc(1'b1, 2'd2, 0, 0, 256, 0, 1'b1, -2048, 0, $sformatf("gtw%0d", k));
      if (k == 1) begin
        idle(-2048, 0, "gtw_idle0");
        idle(-2048, 0, "gtw_idle1");
      end
    end

    // Mid-frame reset during TW, then direct butterflies expose any residue
    @(negedge clk);
    rst      = 1'b1;
    in_valid = 1'b1;
    state    = 2'd1;
    #1 check("midrst_async", 1'b0, 0, 0);
    @(posedge clk);
    #1 check("midrst_hold", 1'b0, 0, 0);
    @(negedge clk);
    rst      = 1'b0;
    in_valid = 1'b0;
    @(posedge clk);
    #1 check("midrst_rel", 1'b0, 0, 0);
    for (int k = 0; k < 8; k++)
      cyc(1'b1, 2'd1, 7, 3, 0, 0, 1'b1, 7, 3, $sformatf("rbf%0d", k));
    for (int k = 0; k < 8; k++)
      cyc(1'b1, 2'd2, 0, 0, 256, 0, 1'b1, -7, -3, $sformatf("rtw%0d", k));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
